// File: rtl/shift_pkg.sv
// Shared types and helpers for the sequential shift unit.
// Build option: SHIFT_SEQ_EARLY_EXIT_EN (consumed by shift_seq).
package shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    RSV = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_e;

  localparam int SEXT_MAX_W = 128;

  // Sign-extends the low n/2 bits of x across the n-bit datapath (n <= SEXT_MAX_W).
  function automatic logic [SEXT_MAX_W-1:0] word_sext(input logic [SEXT_MAX_W-1:0] x,
                                                      input int n);
    logic [SEXT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SEXT_MAX_W; i++) begin
      r[i] = (i < n / 2) ? x[i] : x[n/2-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_seq_stage.sv
// Single radix-2 shift stage: shifts by 2^idx_i in the selected direction,
// or passes the operand through when disabled.
module shift_stage #(
  parameter  int unsigned N = 64,
  localparam int unsigned K = $clog2(N)
) (
  input  logic [N-1:0] operand_i,
  input  logic [K-1:0] idx_i,
  input  logic         dir_i,   // 0 = left, 1 = right
  input  logic         fill_i,
  input  logic         en_i,
  output logic [N-1:0] result_o
);

  logic [K-1:0] amt;
  logic [N-1:0] fill_mask;

  assign amt       = K'(1) << idx_i;
  // Vacated high bits after a right shift take the fill value.
  assign fill_mask = fill_i ? ~({N{1'b1}} >> amt) : '0;

  always_comb begin
    result_o = operand_i;
    if (en_i) begin
      if (dir_i) result_o = (operand_i >> amt) | fill_mask;
      else       result_o = operand_i << amt;
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle SLL/SRL/SRA unit reusing one radix-2 stage per cycle.
// Build option: SHIFT_SEQ_EARLY_EXIT_EN stops once no higher shamt bits remain.
module shift_seq
  import shift_pkg::*;
#(
  parameter  int unsigned N = 64,
  localparam int unsigned K = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  shift_op_e     req_op,
  input  logic          req_word,
  input  logic [K-1:0]  req_shamt,
  input  logic [N-1:0]  req_data,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [N-1:0]  resp_data
);

  seq_state_e   state_q, state_d;
  logic [N-1:0] opnd_q, opnd_d;
  logic [N-1:0] resp_data_q, resp_data_d;
  shift_op_e    op_q, op_d;
  logic         word_q, word_d;
  logic [K-1:0] shamt_q, shamt_d;
  logic [K-1:0] cnt_q, cnt_d;

  logic [N-1:0] accept_opnd, stage_out;
  logic [K-1:0] accept_shamt;
  logic         stage_dir, stage_fill, last_stage;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_data  = resp_data_q;

  // Word right shifts operate on a pre-extended operand so one full-width pass suffices.
  always_comb begin
    accept_opnd  = req_data;
    accept_shamt = req_shamt;
    if (req_word) begin
      accept_shamt[K-1] = 1'b0;
      if (req_op == SRL) accept_opnd = {{(N/2){1'b0}}, req_data[N/2-1:0]};
      else if (req_op == SRA) accept_opnd = N'(word_sext(SEXT_MAX_W'(req_data), N));
    end
  end

  assign stage_dir  = (op_q == SRL) || (op_q == SRA);
  assign stage_fill = (op_q == SRA) && opnd_q[N-1];

  shift_stage #(.N(N)) u_stage (
    .operand_i (opnd_q),
    .idx_i     (cnt_q),
    .dir_i     (stage_dir),
    .fill_i    (stage_fill),
    .en_i      (shamt_q[cnt_q]),
    .result_o  (stage_out)
  );

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  logic [K-1:0] shamt_rest;
  assign shamt_rest = shamt_q >> cnt_q;
  assign last_stage = (shamt_rest >> 1) == '0;
`else
  assign last_stage = (cnt_q == K[K-1:0] - K'(1));
`endif

  always_comb begin
    state_d     = state_q;
    opnd_d      = opnd_q;
    resp_data_d = resp_data_q;
    op_d        = op_q;
    word_d      = word_q;
    shamt_d     = shamt_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = RUN;
          opnd_d  = accept_opnd;
          op_d    = req_op;
          word_d  = req_word;
          shamt_d = accept_shamt;
          cnt_d   = '0;
        end
      end
      RUN: begin
        opnd_d = stage_out;
        cnt_d  = cnt_q + K'(1);
        if (last_stage) begin
          state_d     = DONE;
          resp_data_d = word_q ? N'(word_sext(SEXT_MAX_W'(stage_out), N)) : stage_out;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opnd_q      <= '0;
      resp_data_q <= '0;
      op_q        <= SLL;
      word_q      <= 1'b0;
      shamt_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      resp_data_q <= resp_data_d;
      op_q        <= op_d;
      word_q      <= word_d;
      shamt_q     <= shamt_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
